obstacle_tracker: RTL and testbench

Downstream counterpart of the game-progression state machine. It consumes the per-frame coin and barrier release lane codes, and animates each released object down the screen toward the penguin. It detects lane and height collisions against the player and returns the registered `PENGUIN_HIT` / `COIN_HIT` pulses and the sticky `ZERO_LIVES` flag that the progression logic expects. It also owns the lives counter, the coin score, and the object Y positions used by the sprite compositor.

---
 rtl/obstacle_tracker.sv | 253 +++++++++++++++++++++++++
 tb/tb_obstacle_tracker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_tracker.sv
// ---------------------------------------------------------------------------
// obstacle_tracker
//
// Animates the released coin and barrier objects down the screen, one step
// per enabled frame, and detects lane/height collisions against the penguin.
// Owns the lives counter, the saturating coin score and the sprite Y / VIS
// outputs used by the compositor. All state advances on the rising edge of
// the frame clock.
//
// Ports
//   i_v_sync        in   1   frame clock (rising edge active)
//   i_reset         in   1   synchronous reset, active-high
//   GAME_SWITCH     in   1   run enable; low freezes all state
//   RELEASE_COIN    in   2   coin lane code (00 none, 01 L, 10 M, 11 R)
//   RELEASE_BARRIER in   2   barrier lane code, same encoding
//   PLAYER_LANE     in   2   penguin lane (00 never collides)
//   PLAYER_JUMP     in   1   penguin airborne, barriers cannot hit
//   PENGUIN_HIT     out  1   one-frame pulse on barrier collision
//   COIN_HIT        out  1   one-frame pulse on coin pickup
//   ZERO_LIVES      out  1   sticky until reset
//   LIVES           out  2   remaining lives
//   COIN_COUNT      out  8   coins collected, saturating at 255
//   BARRIER_Y       out 10   barrier sprite Y
//   COIN_Y          out 10   coin sprite Y
//   BARRIER_VIS     out  1   barrier sprite enable
//   COIN_VIS        out  1   coin sprite enable
// ---------------------------------------------------------------------------
module obstacle_tracker #(
    parameter int unsigned SPEED      = 4,
    parameter int unsigned HIT_Y_LO   = 400,
    parameter int unsigned HIT_Y_HI   = 440,
    parameter int unsigned Y_BOTTOM   = 480,
    parameter int unsigned LIVES_INIT = 3
) (
    input  logic       i_v_sync,
    input  logic       i_reset,
    input  logic       GAME_SWITCH,
    input  logic [1:0] RELEASE_COIN,
    input  logic [1:0] RELEASE_BARRIER,
    input  logic [1:0] PLAYER_LANE,
    input  logic       PLAYER_JUMP,
    output logic       PENGUIN_HIT,
    output logic       COIN_HIT,
    output logic       ZERO_LIVES,
    output logic [1:0] LIVES,
    output logic [7:0] COIN_COUNT,
    output logic [9:0] BARRIER_Y,
    output logic [9:0] COIN_Y,
    output logic       BARRIER_VIS,
    output logic       COIN_VIS
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_APPROACH = 2'b01,
        ST_SPENT    = 2'b10
    } obj_state_e;

    // One animated object: FSM state, latched lane and current Y.
    typedef struct packed {
        obj_state_e state;
        logic [1:0] lane;
        logic [9:0] y;
    } obj_t;

    localparam logic [10:0] SPEED_W     = 11'(SPEED);
    localparam logic [10:0] Y_BOTTOM_W  = 11'(Y_BOTTOM);
    localparam logic [9:0]  Y_BOTTOM_Y  = 10'(Y_BOTTOM);
    localparam logic [9:0]  HIT_LO_W    = 10'(HIT_Y_LO);
    localparam logic [9:0]  HIT_HI_W    = 10'(HIT_Y_HI);
    localparam logic [1:0]  LIVES_INIT_W = 2'(LIVES_INIT);

    localparam obj_t OBJ_RESET = '{state: ST_IDLE, lane: 2'b00, y: Y_BOTTOM_Y};

    // True when a Y value lies inside the inclusive collision window.
    function automatic logic in_window(input logic [9:0] y);
        return (y >= HIT_LO_W) && (y <= HIT_HI_W);
    endfunction

    // Next state of one object. 'take' is a collision that the FSM will
    // honour this edge (it already implies release == latched lane).
    // Y is parked at Y_BOTTOM whenever the object leaves APPROACH so the
    // sprite Y output can come straight from the register.
    function automatic obj_t obj_next(input obj_t cur, input logic [1:0] rel,
                                      input logic take);
        obj_t       nxt;
        logic [10:0] sum;
        nxt = cur;
        sum = {1'b0, cur.y} + SPEED_W;
        case (cur.state)
            ST_IDLE: begin
                if (rel != 2'b00) begin
                    nxt.state = ST_APPROACH;
                    nxt.lane  = rel;
                    nxt.y     = 10'd0;
                end else begin
                    nxt = cur;
                end
            end
            ST_APPROACH: begin
                if (rel == 2'b00) begin
                    // Withdrawn upstream: no hit.
                    nxt.state = ST_IDLE;
                    nxt.y     = Y_BOTTOM_Y;
                end else if (rel != cur.lane) begin
                    // Direct lane change restarts the object at the top.
                    nxt.lane = rel;
                    nxt.y    = 10'd0;
                end else if (take) begin
                    nxt.state = ST_SPENT;
                    nxt.y     = Y_BOTTOM_Y;
                end else if (sum >= Y_BOTTOM_W) begin
                    // Fell off the bottom: a miss.
                    nxt.state = ST_SPENT;
                    nxt.y     = Y_BOTTOM_Y;
                end else begin
                    nxt.y = sum[9:0];
                end
            end
            ST_SPENT: begin
                if (rel == 2'b00) begin
                    nxt.state = ST_IDLE;
                end else if (rel != cur.lane) begin
                    nxt.state = ST_APPROACH;
                    nxt.lane  = rel;
                    nxt.y     = 10'd0;
                end else begin
                    // Same release still held: never replayed.
                    nxt = cur;
                end
            end
            default: begin
                nxt = OBJ_RESET;
            end
        endcase
        return nxt;
    endfunction

    obj_t       coin_q,        coin_d;
    obj_t       barrier_q,     barrier_d;
    logic       coin_vis_q,    coin_vis_d;
    logic       barrier_vis_q, barrier_vis_d;
    logic       penguin_hit_q, penguin_hit_d;
    logic       coin_hit_q,    coin_hit_d;
    logic       zero_lives_q,  zero_lives_d;
    logic [1:0] lives_q,       lives_d;
    logic [7:0] coin_count_q,  coin_count_d;

    logic       player_valid_s;
    logic       coin_col_s;
    logic       barrier_col_s;
    logic       coin_take_s;
    logic       barrier_take_s;

    // Collision detection on the current registered Y, before any increment.
    always_comb begin
        player_valid_s = (PLAYER_LANE != 2'b00);

        coin_col_s = (coin_q.state == ST_APPROACH) && in_window(coin_q.y) &&
                     player_valid_s && (coin_q.lane == PLAYER_LANE) &&
                     !zero_lives_q;

        barrier_col_s = (barrier_q.state == ST_APPROACH) && in_window(barrier_q.y) &&
                        player_valid_s && (barrier_q.lane == PLAYER_LANE) &&
                        !PLAYER_JUMP && !zero_lives_q;

        // A withdrawal or lane change on the same edge takes priority over
        // the collision, so only count hits the FSM will actually act on.
        coin_take_s    = coin_col_s    && (RELEASE_COIN    == coin_q.lane);
        barrier_take_s = barrier_col_s && (RELEASE_BARRIER == barrier_q.lane);
    end

    // Next-state computation for both objects, score, lives and hit pulses.
    always_comb begin
        coin_d        = coin_q;
        barrier_d     = barrier_q;
        coin_vis_d    = coin_vis_q;
        barrier_vis_d = barrier_vis_q;
        penguin_hit_d = 1'b0;
        coin_hit_d    = 1'b0;
        zero_lives_d  = zero_lives_q;
        lives_d       = lives_q;
        coin_count_d  = coin_count_q;

        if (GAME_SWITCH) begin
            coin_d    = obj_next(coin_q,    RELEASE_COIN,    coin_take_s);
            barrier_d = obj_next(barrier_q, RELEASE_BARRIER, barrier_take_s);

            coin_vis_d    = (coin_d.state    == ST_APPROACH);
            barrier_vis_d = (barrier_d.state == ST_APPROACH);

            penguin_hit_d = barrier_take_s;
            coin_hit_d    = coin_take_s;

            if (barrier_take_s && (lives_q != 2'd0)) begin
                lives_d = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                    zero_lives_d = 1'b1;
                end else begin
                    zero_lives_d = zero_lives_q;
                end
            end else begin
                lives_d = lives_q;
            end

            if (coin_take_s && (coin_count_q != 8'd255)) begin
                coin_count_d = coin_count_q + 8'd1;
            end else begin
                coin_count_d = coin_count_q;
            end
        end else begin
            // Frozen frame: everything holds, pulses forced low.
            penguin_hit_d = 1'b0;
            coin_hit_d    = 1'b0;
        end
    end

    // State registers with synchronous reset taking priority over all events.
    always_ff @(posedge i_v_sync) begin
        if (i_reset) begin
            coin_q        <= OBJ_RESET;
            barrier_q     <= OBJ_RESET;
            coin_vis_q    <= 1'b0;
            barrier_vis_q <= 1'b0;
            penguin_hit_q <= 1'b0;
            coin_hit_q    <= 1'b0;
            zero_lives_q  <= 1'b0;
            lives_q       <= LIVES_INIT_W;
            coin_count_q  <= 8'd0;
        end else begin
            coin_q        <= coin_d;
            barrier_q     <= barrier_d;
            coin_vis_q    <= coin_vis_d;
            barrier_vis_q <= barrier_vis_d;
            penguin_hit_q <= penguin_hit_d;
            coin_hit_q    <= coin_hit_d;
            zero_lives_q  <= zero_lives_d;
            lives_q       <= lives_d;
            coin_count_q  <= coin_count_d;
        end
    end

    assign PENGUIN_HIT = penguin_hit_q;
    assign COIN_HIT    = coin_hit_q;
    assign ZERO_LIVES  = zero_lives_q;
    assign LIVES       = lives_q;
    assign COIN_COUNT  = coin_count_q;
    assign BARRIER_Y   = barrier_q.y;
    assign COIN_Y      = coin_q.y;
    assign BARRIER_VIS = barrier_vis_q;
    assign COIN_VIS    = coin_vis_q;

endmodule

// File: tb/tb_obstacle_tracker.sv
// ---------------------------------------------------------------------------
// tb_obstacle_tracker
//
// Drives directed scenarios followed by randomized release/lane/jump/enable
// sequences, and compares every output after every frame against a
// behavioural model of the object rules kept in this bench.
// ---------------------------------------------------------------------------
module tb_obstacle_tracker;

    logic       clk;
    logic       rst;
    logic       sw;
    logic [1:0] rel_c;
    logic [1:0] rel_b;
    logic [1:0] lane;
    logic       jump;

    logic       penguin_hit;
    logic       coin_hit;
    logic       zero_lives;
    logic [1:0] lives;
    logic [7:0] coin_count;
    logic [9:0] barrier_y;
    logic [9:0] coin_y;
    logic       barrier_vis;
    logic       coin_vis;

    obstacle_tracker dut (
        .i_v_sync        (clk),
        .i_reset         (rst),
        .GAME_SWITCH     (sw),
        .RELEASE_COIN    (rel_c),
        .RELEASE_BARRIER (rel_b),
        .PLAYER_LANE     (lane),
        .PLAYER_JUMP     (jump),
        .PENGUIN_HIT     (penguin_hit),
        .COIN_HIT        (coin_hit),
        .ZERO_LIVES      (zero_lives),
        .LIVES           (lives),
        .COIN_COUNT      (coin_count),
        .BARRIER_Y       (barrier_y),
        .COIN_Y          (coin_y),
        .BARRIER_VIS     (barrier_vis),
        .COIN_VIS        (coin_vis)
    );

    // Frame clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 = coin, 1 = barrier.
    int m_act   [2];
    int m_spent [2];
    int m_lane  [2];
    int m_y     [2];
    int m_lives;
    int m_zero;
    int m_coins;
    int m_phit;
    int m_chit;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int rel [2];
        int hit [2];
        rel[0] = int'(rel_c);
        rel[1] = int'(rel_b);
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_act[k] = 0; m_spent[k] = 0; m_lane[k] = 0; m_y[k] = 480;
            end
            m_lives = 3; m_zero = 0; m_coins = 0; m_phit = 0; m_chit = 0;
        end else if (!sw) begin
            m_phit = 0;
            m_chit = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                hit[k] = (m_act[k] != 0 && m_y[k] >= 400 && m_y[k] <= 440 &&
                          int'(lane) != 0 && int'(lane) == m_lane[k] &&
                          rel[k] == m_lane[k] && m_zero == 0 &&
                          (k == 0 || jump == 1'b0)) ? 1 : 0;
            end
            for (int k = 0; k < 2; k++) begin
                if (m_act[k] == 0 && m_spent[k] == 0) begin
                    if (rel[k] != 0) begin
                        m_act[k] = 1; m_lane[k] = rel[k]; m_y[k] = 0;
                    end
                end else if (m_act[k] != 0) begin
                    if (rel[k] == 0) begin
                        m_act[k] = 0;
                    end else if (rel[k] != m_lane[k]) begin
                        m_lane[k] = rel[k]; m_y[k] = 0;
                    end else if (hit[k] != 0 || m_y[k] + 4 >= 480) begin
                        m_act[k] = 0; m_spent[k] = 1;
                    end else begin
                        m_y[k] = m_y[k] + 4;
                    end
                end else begin
                    if (rel[k] == 0) begin
                        m_spent[k] = 0;
                    end else if (rel[k] != m_lane[k]) begin
                        m_spent[k] = 0; m_act[k] = 1; m_lane[k] = rel[k]; m_y[k] = 0;
                    end
                end
            end
            m_chit = hit[0];
            m_phit = hit[1];
            if (hit[1] != 0 && m_lives > 0) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_zero = 1;
            end
            if (hit[0] != 0 && m_coins < 255) m_coins = m_coins + 1;
        end
    endtask

    task automatic check_all();
        chk_eq("penguin_hit", int'(penguin_hit), m_phit);
        chk_eq("coin_hit",    int'(coin_hit),    m_chit);
        chk_eq("zero_lives",  int'(zero_lives),  m_zero);
        chk_eq("lives",       int'(lives),       m_lives);
        chk_eq("coin_count",  int'(coin_count),  m_coins);
        chk_eq("coin_vis",    int'(coin_vis),    m_act[0]);
        chk_eq("barrier_vis", int'(barrier_vis), m_act[1]);
        chk_eq("coin_y",      int'(coin_y),      (m_act[0] != 0) ? m_y[0] : 480);
        chk_eq("barrier_y",   int'(barrier_y),   (m_act[1] != 0) ? m_y[1] : 480);
    endtask

    // One frame: edge, model update, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; sw = 1'b1; rel_c = 2'b00; rel_b = 2'b00; lane = 2'b00; jump = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    int first;
    int pulses;
    int exp_lives [4];
    int cnt_c, cnt_b, cnt_l, cnt_j, cnt_s;

    initial begin
        rst = 1'b1; sw = 1'b0; rel_c = 2'b00; rel_b = 2'b00; lane = 2'b00; jump = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_spent[k] = 0; m_lane[k] = 0; m_y[k] = 480;
        end
        m_lives = 3; m_zero = 0; m_coins = 0; m_phit = 0; m_chit = 0;

        // Reset defaults.
        do_reset();
        step();
        chk_eq("rst_lives", int'(lives), 3);
        chk_eq("rst_coins", int'(coin_count), 0);
        chk_eq("rst_cvis",  int'(coin_vis), 0);
        chk_eq("rst_bvis",  int'(barrier_vis), 0);
        chk_eq("rst_cy",    int'(coin_y), 480);
        chk_eq("rst_by",    int'(barrier_y), 480);
        chk_eq("rst_flags", int'({penguin_hit, coin_hit, zero_lives}), 0);

        // Coin pickup in the middle lane, release held afterwards.
        lane = 2'b10; rel_c = 2'b10; first = -1; pulses = 0;
        for (int e = 0; e <= 140; e++) begin
            step();
            if (coin_hit) begin
                pulses++;
                if (first < 0) first = e;
            end
        end
        chk_eq("coin_hit_edge",   first, 101);
        chk_eq("coin_hit_pulses", pulses, 1);
        chk_eq("coin_count_1",    int'(coin_count), 1);
        chk_eq("coin_vis_spent",  int'(coin_vis), 0);
        rel_c = 2'b00;
        step();

        // Barrier jumped over; retires as a miss.
        lane = 2'b01; rel_b = 2'b01; first = -1; pulses = 0;
        for (int e = 0; e <= 125; e++) begin
            jump = (e >= 95) ? 1'b1 : 1'b0;
            step();
            if (penguin_hit) pulses++;
            if (!barrier_vis && first < 0) first = e;
        end
        jump = 1'b0;
        chk_eq("jump_no_hit",  pulses, 0);
        chk_eq("jump_retire",  first, 120);
        chk_eq("jump_lives",   int'(lives), 3);
        rel_b = 2'b00;
        step();

        // Three fatal barriers, then a fourth that must be ignored.
        exp_lives[0] = 2; exp_lives[1] = 1; exp_lives[2] = 0; exp_lives[3] = 0;
        for (int h = 0; h < 4; h++) begin
            rel_b = 2'b01; pulses = 0;
            for (int e = 0; e <= 102; e++) begin
                step();
                if (penguin_hit) begin
                    pulses++;
                    if (h == 2) chk_eq("zero_on_third_edge", int'(zero_lives), 1);
                end
            end
            rel_b = 2'b00;
            step();
            chk_eq("fatal_lives", int'(lives), exp_lives[h]);
            chk_eq("fatal_pulses", pulses, (h < 3) ? 1 : 0);
        end
        chk_eq("zero_lives_sticky", int'(zero_lives), 1);

        // Direct coin lane change restarts Y; player elsewhere never hits.
        do_reset();
        lane = 2'b11; rel_c = 2'b11;
        for (int e = 0; e < 50; e++) step();
        rel_c = 2'b01;
        step();
        chk_eq("lc_y_restart", int'(coin_y), 0);
        chk_eq("lc_vis",       int'(coin_vis), 1);
        pulses = 0;
        for (int e = 0; e < 130; e++) begin
            step();
            if (coin_hit) pulses++;
        end
        chk_eq("lc_no_hit", pulses, 0);
        rel_c = 2'b00;
        step();

        // Simultaneous coin and barrier hits, then a frozen stretch.
        do_reset();
        lane = 2'b10; rel_c = 2'b10; rel_b = 2'b10;
        for (int e = 0; e <= 101; e++) step();
        chk_eq("sim_coin_hit",  int'(coin_hit), 1);
        chk_eq("sim_peng_hit",  int'(penguin_hit), 1);
        chk_eq("sim_lives",     int'(lives), 2);
        chk_eq("sim_coins",     int'(coin_count), 1);
        rel_c = 2'b00; rel_b = 2'b00;
        step();
        rel_c = 2'b01; rel_b = 2'b01;
        step();
        for (int e = 1; e <= 29; e++) step();
        sw = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk_eq("frz_coin_y",    int'(coin_y), 116);
            chk_eq("frz_barrier_y", int'(barrier_y), 116);
            chk_eq("frz_pulses",    int'({coin_hit, penguin_hit}), 0);
        end
        sw = 1'b1;
        step();
        chk_eq("unfrz_coin_y", int'(coin_y), 120);
        rel_c = 2'b00; rel_b = 2'b00;
        step();

        // Coin score saturation.
        do_reset();
        lane = 2'b10;
        for (int n = 0; n < 258; n++) begin
            rel_c = 2'b10;
            for (int e = 0; e <= 101; e++) step();
            rel_c = 2'b00;
            step();
        end
        chk_eq("coin_saturate", int'(coin_count), 255);

        // Randomized phase.
        do_reset();
        cnt_c = 0; cnt_b = 0; cnt_l = 0; cnt_j = 0; cnt_s = 0;
        for (int f = 0; f < 6000; f++) begin
            if (cnt_c == 0) begin rel_c = 2'($urandom_range(0, 3)); cnt_c = $urandom_range(1, 160); end
            if (cnt_b == 0) begin rel_b = 2'($urandom_range(0, 3)); cnt_b = $urandom_range(1, 160); end
            if (cnt_l == 0) begin lane  = 2'($urandom_range(0, 3)); cnt_l = $urandom_range(1, 120); end
            if (cnt_j == 0) begin jump  = ($urandom_range(0, 3) == 0); cnt_j = $urandom_range(1, 30); end
            if (cnt_s == 0) begin sw    = ($urandom_range(0, 7) != 0); cnt_s = $urandom_range(1, 12); end
            rst = ($urandom_range(0, 999) == 0);
            cnt_c--; cnt_b--; cnt_l--; cnt_j--; cnt_s--;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
